if_id_skid_reg: RTL

// - Fetch-to-decode pipeline register with 2-entry skid buffer and valid/ready handshakes.
// - Captures instruction word + PC+4 from fetch; splits instruction into MIPS fields for decode.
// - imm16 output drives the 16->32 sign-extension stage directly; opcode/rs/rt/rd/funct feed control and register file.
// - Provides stall (backpressure) and flush (branch/jump redirect) without dropping or duplicating instructions.

---
 rtl/if_id_skid_reg.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/if_id_skid_reg.sv
// Fetch-to-decode pipeline register with a 2-entry skid buffer (head H, skid S).
// Decode fields are sliced combinationally from H, which is zero whenever the buffer is empty.
module if_id_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_instr,
    input  logic [WIDTH-1:0] in_pcplus4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pcplus4,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [15:0]      imm16,
    output logic [25:0]      addr26
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_h_instr;
    logic [WIDTH-1:0] r_h_pc;
    logic [WIDTH-1:0] r_s_instr;
    logic [WIDTH-1:0] r_s_pc;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_h_instr_nxt;
    logic [WIDTH-1:0] w_h_pc_nxt;
    logic [WIDTH-1:0] w_s_instr_nxt;
    logic [WIDTH-1:0] w_s_pc_nxt;
    logic             w_accept;
    logic             w_consume;

    // Handshake flags depend on registered state only, so out_ready never reaches in_ready.
    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_consume = out_valid & out_ready;

    assign out_pcplus4 = r_h_pc;
    assign opcode      = r_h_instr[31:26];
    assign rs          = r_h_instr[25:21];
    assign rt          = r_h_instr[20:16];
    assign rd          = r_h_instr[15:11];
    assign shamt       = r_h_instr[10:6];
    assign funct       = r_h_instr[5:0];
    assign imm16       = r_h_instr[15:0];
    assign addr26      = r_h_instr[25:0];

    // Next-state and next-storage selection; flush empties everything and wins over any handshake.
    always_comb begin
        w_state_nxt   = r_state;
        w_h_instr_nxt = r_h_instr;
        w_h_pc_nxt    = r_h_pc;
        w_s_instr_nxt = r_s_instr;
        w_s_pc_nxt    = r_s_pc;
        if (flush) begin
            w_state_nxt   = ST_EMPTY;
            w_h_instr_nxt = {WIDTH{1'b0}};
            w_h_pc_nxt    = {WIDTH{1'b0}};
            w_s_instr_nxt = {WIDTH{1'b0}};
            w_s_pc_nxt    = {WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt   = ST_ONE;
                        w_h_instr_nxt = in_instr;
                        w_h_pc_nxt    = in_pcplus4;
                    end else begin
                        w_state_nxt   = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        w_h_instr_nxt = in_instr;
                        w_h_pc_nxt    = in_pcplus4;
                    end else if (w_accept) begin
                        w_state_nxt   = ST_FULL;
                        w_s_instr_nxt = in_instr;
                        w_s_pc_nxt    = in_pcplus4;
                    end else if (w_consume) begin
                        // Clear H so the field outputs read zero while empty.
                        w_state_nxt   = ST_EMPTY;
                        w_h_instr_nxt = {WIDTH{1'b0}};
                        w_h_pc_nxt    = {WIDTH{1'b0}};
                    end else begin
                        w_state_nxt   = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_consume) begin
                        w_state_nxt   = ST_ONE;
                        w_h_instr_nxt = r_s_instr;
                        w_h_pc_nxt    = r_s_pc;
                        w_s_instr_nxt = {WIDTH{1'b0}};
                        w_s_pc_nxt    = {WIDTH{1'b0}};
                    end else begin
                        w_state_nxt   = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt   = ST_EMPTY;
                    w_h_instr_nxt = {WIDTH{1'b0}};
                    w_h_pc_nxt    = {WIDTH{1'b0}};
                    w_s_instr_nxt = {WIDTH{1'b0}};
                    w_s_pc_nxt    = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // State and storage registers; reset takes priority over flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_EMPTY;
            r_h_instr <= {WIDTH{1'b0}};
            r_h_pc    <= {WIDTH{1'b0}};
            r_s_instr <= {WIDTH{1'b0}};
            r_s_pc    <= {WIDTH{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_h_instr <= w_h_instr_nxt;
            r_h_pc    <= w_h_pc_nxt;
            r_s_instr <= w_s_instr_nxt;
            r_s_pc    <= w_s_pc_nxt;
        end
    end

endmodule
